ip_uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (send_data/send_req/send_busy) between NUM_REQ byte-stream requesters
//  (debugger, status dumpers). Round-robin grant; a grant is held for a whole message, up to the

---
 rtl/ip_uart_tx_arbiter_pkg.sv | 26 ++
 rtl/ip_uart_rr_pick.sv | 32 +++
 rtl/ip_uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_ip_uart_tx_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_uart_tx_arbiter_pkg.sv
// Shared state encoding, widths and round-robin helper for the UART transmit arbiter.
package ip_uart_tx_arbiter_pkg;

  localparam int ID_W  = 2;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Pointer value following a released holder, wrapping at num_req.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id, input int num_req);
    logic [ID_W-1:0] nxt;
    if (int'(id) >= num_req - 1) begin
      nxt = '0;
    end else begin
      nxt = id + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ip_uart_rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr, modulo NUM_REQ.
module ip_uart_rr_pick
  import ip_uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  // Smallest rotational distance from ptr among the valid requesters wins.
  always_comb begin
    int   d;
    int   best_d;
    logic take;
    found  = 1'b0;
    index  = '0;
    best_d = NUM_REQ;
    d      = 0;
    take   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d      = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + NUM_REQ - int'(ptr));
      take   = valid[j] && (d < best_d);
      best_d = take ? d : best_d;
      index  = take ? ID_W'(j) : index;
      found  = found | take;
    end
  end

endmodule

// File: rtl/ip_uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters; a round-robin grant
// is held for a whole message and withdrawn from a holder that stalls for IDLE_LIMIT cycles.
module ip_uart_tx_arbiter
  import ip_uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int IDLE_LIMIT = 255
) (
  input  logic                 n_reset,
  input  logic                 clk,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           send_data,
  output logic                 send_req,
  input  logic                 send_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  state_t           state_r, state_nxt;
  logic [ID_W-1:0]  ptr_r, ptr_nxt, grant_id_nxt;
  logic [CNT_W-1:0] idle_cnt_r, idle_cnt_nxt;
  logic [7:0]       send_data_nxt;
  logic             send_req_nxt, grant_valid_nxt, last_r, last_nxt, do_release;
  logic             pick_found;
  logic [ID_W-1:0]  pick_index;
  logic             sel_valid, sel_last;
  logic [7:0]       sel_data;

  ip_uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_r),
    .found (pick_found),
    .index (pick_index)
  );

  // Holder's lanes muxed out; ready only toward the holder while waiting for a byte.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_valid    = sel_valid | (req_valid[i] & (grant_id == ID_W'(i)));
      sel_last     = sel_last  | (req_last[i]  & (grant_id == ID_W'(i)));
      sel_data     = sel_data  | (req_data[8*i +: 8] & {8{grant_id == ID_W'(i)}});
      req_ready[i] = (state_r == ST_LOAD) && (grant_id == ID_W'(i));
    end
  end

  // Next-state and next-register values for the grant/transmit sequence.
  always_comb begin
    state_nxt       = state_r;
    ptr_nxt         = ptr_r;
    grant_id_nxt    = grant_id;
    grant_valid_nxt = grant_valid;
    idle_cnt_nxt    = idle_cnt_r;
    send_data_nxt   = send_data;
    send_req_nxt    = send_req;
    last_nxt        = last_r;
    do_release      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_nxt    = pick_index;
          grant_valid_nxt = 1'b1;
          idle_cnt_nxt    = '0;
          state_nxt       = ST_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (sel_valid) begin
          send_data_nxt = sel_data;
          last_nxt      = sel_last;
          send_req_nxt  = 1'b1;
          state_nxt     = ST_ISSUE;
        end else if (idle_cnt_r == CNT_W'(IDLE_LIMIT - 1)) begin
          do_release = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          idle_cnt_nxt = idle_cnt_r + 8'd1;
        end
      end
      ST_ISSUE: begin
        if (!send_busy) begin
          send_req_nxt = 1'b0;
          state_nxt    = ST_GAP;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      // UART raises busy during this cycle, so it is not looked at yet.
      ST_GAP: state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (send_busy) begin
          state_nxt = ST_DRAIN;
        end else if (last_r) begin
          do_release = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          idle_cnt_nxt = '0;
          state_nxt    = ST_LOAD;
        end
      end
      default: begin
        send_req_nxt    = 1'b0;
        grant_valid_nxt = 1'b0;
        state_nxt       = ST_IDLE;
      end
    endcase
    if (do_release) begin
      grant_valid_nxt = 1'b0;
      ptr_nxt         = rr_next(grant_id, NUM_REQ);
    end else begin
      ptr_nxt = ptr_nxt;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      idle_cnt_r  <= '0;
      send_data   <= 8'h00;
      send_req    <= 1'b0;
      last_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      ptr_r       <= ptr_nxt;
      grant_id    <= grant_id_nxt;
      grant_valid <= grant_valid_nxt;
      idle_cnt_r  <= idle_cnt_nxt;
      send_data   <= send_data_nxt;
      send_req    <= send_req_nxt;
      last_r      <= last_nxt;
    end
  end

endmodule

// File: tb/tb_ip_uart_tx_arbiter.sv
// Self-checking bench: requester queues and a UART busy model driven every negedge, with a
// message-level round-robin model predicting the byte stream seen by the UART.
`timescale 1ns/1ps
module tb_ip_uart_tx_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int IDLE_LIMIT = 8;

  logic                 clk = 1'b0;
  logic                 n_reset;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid, req_last, req_ready;
  logic [7:0]           send_data;
  logic                 send_req, send_busy, grant_valid;
  logic [1:0]           grant_id;

  always #5 clk = ~clk;

  ip_uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDLE_LIMIT(IDLE_LIMIT)) dut (
    .n_reset(n_reset), .clk(clk), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .send_data(send_data), .send_req(send_req),
    .send_busy(send_busy), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]         msg_q [NUM_REQ][$];   // {last, data}
  logic [NUM_REQ-1:0] en;
  logic               force_busy;
  int                 busy_len, busy_cnt;
  bit                 rnd_busy, acc_pend;
  logic [NUM_REQ-1:0] xfer_prev;
  logic [7:0]         log_data[$];
  logic [1:0]         log_id[$];
  logic [7:0]         exp_data[$];
  logic [1:0]         exp_id[$];

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en[i] && msg_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = msg_q[i][0][7:0];
        req_last[i]        = msg_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
  endtask

  // One clock: update UART busy and requester queues, drive inputs, note what the next edge takes.
  task automatic tick();
    @(negedge clk);
    if (acc_pend) busy_cnt = rnd_busy ? int'($urandom_range(1, 6)) : busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    for (int i = 0; i < NUM_REQ; i++)
      if (xfer_prev[i] && msg_q[i].size() > 0) void'(msg_q[i].pop_front());
    drive();
    send_busy = force_busy || (busy_cnt > 0);
    acc_pend  = send_req && !send_busy;
    if (acc_pend) begin
      log_data.push_back(send_data);
      log_id.push_back(grant_id);
    end
    xfer_prev = req_valid & req_ready & {NUM_REQ{n_reset}};
  endtask

  task automatic do_reset();
    n_reset = 1'b0; en = '0; force_busy = 1'b0; busy_cnt = 0; acc_pend = 1'b0; xfer_prev = '0;
    for (int i = 0; i < NUM_REQ; i++) msg_q[i].delete();
    tick(); tick();
    n_reset = 1'b1;
    log_data.delete(); log_id.delete();
  endtask

  // Message-level model: every queued message is pending, grants rotate from start_ptr.
  task automatic model_order(input int start_ptr);
    logic [8:0] qs [NUM_REQ][$];
    logic [8:0] e;
    int p, sel;
    exp_data.delete(); exp_id.delete();
    for (int i = 0; i < NUM_REQ; i++) qs[i] = msg_q[i];
    p = start_ptr;
    for (int guard = 0; guard < 1000; guard++) begin
      sel = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int j = (p + k) % NUM_REQ;
        if (sel < 0 && qs[j].size() > 0) sel = j;
      end
      if (sel < 0) break;
      do begin
        e = qs[sel].pop_front();
        exp_data.push_back(e[7:0]);
        exp_id.push_back(2'(sel));
      end while (!e[8] && qs[sel].size() > 0);
      p = (sel + 1) % NUM_REQ;
    end
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (log_data.size() >= n && !grant_valid && busy_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    do_reset();
    n_checks++;
    if (send_req !== 1'b0 || req_ready !== 4'b0000 || grant_valid !== 1'b0 ||
        grant_id !== 2'd0 || send_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: req=%b ready=%b gv=%b gid=%0d data=%02h, want 0/0000/0/0/00",
               send_req, req_ready, grant_valid, grant_id, send_data);
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      if (send_req !== 1'b0 || req_ready !== 4'b0000 || grant_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
  endtask

  task automatic test_message();
    int pulses = 0, lat = -1, last_acc = 0, rel = -1;
    bit prev_req = 1'b0, seen = 1'b0, ok;
    logic [7:0] want [4] = '{8'h41, 8'h42, 8'h0D, 8'h0A};
    do_reset();
    rnd_busy = 1'b0; busy_len = 10;
    for (int k = 0; k < 4; k++) msg_q[0].push_back({1'(k == 3), want[k]});
    en[0] = 1'b1;
    tick();
    for (int c = 1; c <= 300; c++) begin
      int sz = log_data.size();
      tick();
      if (log_data.size() != sz) last_acc = c;
      if (send_req && !prev_req) begin pulses++; if (pulses == 1) lat = c; end
      prev_req = send_req;
      if (grant_valid) seen = 1'b1;
      if (seen && !grant_valid) begin rel = c - last_acc; break; end
    end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL msg_latency: %0d cycles, want 2", lat); end
    n_checks++;
    if (pulses !== 4) begin n_fail++; $display("FAIL msg_pulses: %0d, want 4", pulses); end
    n_checks++;
    if (log_data.size() !== 4) begin n_fail++; $display("FAIL msg_count: %0d, want 4", log_data.size()); end
    for (int k = 0; k < 4 && k < log_data.size(); k++) begin
      n_checks++;
      if (log_data[k] !== want[k] || log_id[k] !== 2'd0) begin
        n_fail++;
        $display("FAIL msg_byte[%0d]: id%0d %02h, want id0 %02h", k, log_id[k], log_data[k], want[k]);
      end
    end
    n_checks++;
    if (rel !== busy_len + 2) begin n_fail++; $display("FAIL msg_release: %0d cycles after accept, want %0d", rel, busy_len + 2); end
    // Pointer now 1: simultaneous req0/req1 must serve req1 first.
    log_data.delete(); log_id.delete();
    msg_q[0].push_back({1'b1, 8'h30});
    msg_q[1].push_back({1'b1, 8'h31});
    model_order(1);
    en = 4'b0011; busy_len = 2;
    run_until(2, 200, ok);
    n_checks++;
    if (!ok || log_data.size() !== 2) begin n_fail++; $display("FAIL ptr_after_msg: %0d bytes, want 2", log_data.size()); end
    for (int k = 0; k < 2 && k < log_data.size(); k++) begin
      n_checks++;
      if (log_data[k] !== exp_data[k] || log_id[k] !== exp_id[k]) begin
        n_fail++;
        $display("FAIL ptr_after_msg[%0d]: id%0d %02h, want id%0d %02h", k, log_id[k], log_data[k], exp_id[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_two_requesters();
    bit ok;
    do_reset();
    rnd_busy = 1'b0; busy_len = 4;
    msg_q[0] = '{{1'b0, 8'h10}, {1'b1, 8'h11}, {1'b0, 8'h12}, {1'b0, 8'h13}, {1'b1, 8'h14}};
    msg_q[2] = '{{1'b0, 8'h20}, {1'b0, 8'h21}, {1'b1, 8'h22}};
    model_order(0);
    en = 4'b0101;
    run_until(exp_data.size(), 600, ok);
    n_checks++;
    if (!ok || log_data.size() !== exp_data.size()) begin
      n_fail++; $display("FAIL rr_count: %0d bytes, want %0d", log_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < log_data.size(); k++) begin
      n_checks++;
      if (log_data[k] !== exp_data[k] || log_id[k] !== exp_id[k]) begin
        n_fail++;
        $display("FAIL rr_byte[%0d]: id%0d %02h, want id%0d %02h", k, log_id[k], log_data[k], exp_id[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_forced_release();
    int cnt = 0, nh_bad = 0;
    bit ok;
    logic [7:0] want_d [7] = '{8'h5A, 8'hC1, 8'hC2, 8'hC3, 8'hD1, 8'hD2, 8'hD3};
    logic [1:0] want_i [7] = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    do_reset();
    rnd_busy = 1'b0; busy_len = 3;
    msg_q[1].push_back({1'b0, 8'h5A});
    msg_q[3] = '{{1'b0, 8'hC1}, {1'b0, 8'hC2}, {1'b1, 8'hC3}};
    msg_q[0] = '{{1'b0, 8'hD1}, {1'b0, 8'hD2}, {1'b1, 8'hD3}};
    en = 4'b1010;
    for (int c = 0; c < 100 && log_data.size() == 0; c++) tick();
    en[0] = 1'b1;
    for (int c = 0; c < 100 && req_ready[1] !== 1'b1; c++) tick();
    while (req_ready[1] === 1'b1 && cnt < 100) begin
      cnt++;
      if (req_ready[3] !== 1'b0 || req_ready[0] !== 1'b0) nh_bad++;
      tick();
    end
    n_checks++;
    if (cnt !== IDLE_LIMIT) begin n_fail++; $display("FAIL idle_limit: %0d LOAD cycles, want %0d", cnt, IDLE_LIMIT); end
    n_checks++;
    if (nh_bad !== 0) begin n_fail++; $display("FAIL non_holder_ready: %0d cycles, want 0", nh_bad); end
    n_checks++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd1) begin
      n_fail++; $display("FAIL forced_release: gv=%b gid=%0d, want gv=0 gid=1", grant_valid, grant_id);
    end
    tick();
    n_checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
      n_fail++; $display("FAIL regrant_ptr2: gv=%b gid=%0d, want gv=1 gid=3", grant_valid, grant_id);
    end
    run_until(7, 400, ok);
    n_checks++;
    if (!ok || log_data.size() !== 7) begin n_fail++; $display("FAIL trunc_count: %0d bytes, want 7", log_data.size()); end
    for (int k = 0; k < 7 && k < log_data.size(); k++) begin
      n_checks++;
      if (log_data[k] !== want_d[k] || log_id[k] !== want_i[k]) begin
        n_fail++;
        $display("FAIL trunc_byte[%0d]: id%0d %02h, want id%0d %02h", k, log_id[k], log_data[k], want_i[k], want_d[k]);
      end
    end
  endtask

  task automatic test_busy_stall();
    int bad = 0;
    bit ok;
    do_reset();
    rnd_busy = 1'b0; busy_len = 2; force_busy = 1'b1;
    msg_q[0].push_back({1'b1, 8'hA7});
    en[0] = 1'b1;
    for (int c = 0; c < 20 && send_req !== 1'b1; c++) tick();
    for (int k = 0; k < 20; k++) begin
      if (send_req !== 1'b1 || send_data !== 8'hA7) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0 || log_data.size() !== 0) begin
      n_fail++; $display("FAIL stall_hold: %0d unstable cycles, %0d accepted, want 0/0", bad, log_data.size());
    end
    force_busy = 1'b0;
    tick();
    tick();
    n_checks++;
    if (send_req !== 1'b0 || log_data.size() !== 1) begin
      n_fail++; $display("FAIL stall_accept: req=%b accepted=%0d, want req=0 accepted=1", send_req, log_data.size());
    end
    run_until(1, 100, ok);
    n_checks++;
    if (!ok || log_data.size() !== 1 || log_data[0] !== 8'hA7) begin
      n_fail++; $display("FAIL stall_byte: %0d bytes, want one A7", log_data.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    rnd_busy = 1'b0; busy_len = 2; force_busy = 1'b1;
    msg_q[2].push_back({1'b1, 8'h55});
    en[2] = 1'b1;
    for (int c = 0; c < 20 && send_req !== 1'b1; c++) tick();
    n_checks++;
    if (send_req !== 1'b1 || send_data !== 8'h55 || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL mid_issue: req=%b data=%02h gid=%0d, want 1/55/2", send_req, send_data, grant_id);
    end
    n_reset = 1'b0; en = '0; msg_q[2].delete();
    tick();
    n_checks++;
    if (send_req !== 1'b0 || grant_valid !== 1'b0 || req_ready !== 4'b0000 ||
        grant_id !== 2'd0 || send_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b gv=%b ready=%b gid=%0d data=%02h, want 0/0/0000/0/00",
               send_req, grant_valid, req_ready, grant_id, send_data);
    end
    n_reset = 1'b1;
    log_data.delete(); log_id.delete();
    msg_q[0] = '{{1'b0, 8'h61}, {1'b0, 8'h62}, {1'b1, 8'h63}};
    model_order(0);
    en[0] = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    n_checks++;
    if (send_req !== 1'b1 || log_data.size() !== 0) begin
      n_fail++; $display("FAIL post_reset_wait: req=%b accepted=%0d, want 1/0", send_req, log_data.size());
    end
    force_busy = 1'b0;
    run_until(exp_data.size(), 200, ok);
    n_checks++;
    if (!ok || log_data.size() !== exp_data.size()) begin
      n_fail++; $display("FAIL post_reset_count: %0d bytes, want %0d", log_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < log_data.size(); k++) begin
      n_checks++;
      if (log_data[k] !== exp_data[k] || log_id[k] !== exp_id[k]) begin
        n_fail++;
        $display("FAIL post_reset_byte[%0d]: id%0d %02h, want id%0d %02h", k, log_id[k], log_data[k], exp_id[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    bit done = 1'b0;
    do_reset();
    rnd_busy = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int nm = int'($urandom_range(0, 3));
      for (int m = 0; m < nm; m++) begin
        int len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) msg_q[i].push_back({1'(b == len - 1), 8'($urandom)});
      end
    end
    model_order(0);
    en = '1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (req_ready !== 4'b0000 && (req_ready !== (4'b0001 << grant_id) || grant_valid !== 1'b1)) bad++;
      if (log_data.size() >= exp_data.size() && !grant_valid && busy_cnt == 0) begin done = 1'b1; break; end
    end
    n_checks++;
    if (!done || bad !== 0) begin n_fail++; $display("FAIL rand_run: done=%b ready_errors=%0d, want 1/0", done, bad); end
    n_checks++;
    if (log_data.size() !== exp_data.size()) begin
      n_fail++; $display("FAIL rand_count: %0d bytes, want %0d", log_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < log_data.size(); k++) begin
      n_checks++;
      if (log_data[k] !== exp_data[k] || log_id[k] !== exp_id[k]) begin
        n_fail++;
        $display("FAIL rand_byte[%0d]: id%0d %02h, want id%0d %02h", k, log_id[k], log_data[k], exp_id[k], exp_data[k]);
      end
    end
  endtask

  initial begin
    n_reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0; send_busy = 1'b0;
    en = '0; force_busy = 1'b0; busy_len = 2; busy_cnt = 0; rnd_busy = 1'b0;
    acc_pend = 1'b0; xfer_prev = '0;
    test_reset();
    test_message();
    test_two_requesters();
    test_forced_release();
    test_busy_stall();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
